prefetch_arbiter: RTL and testbench

Three-way arbiter sharing the single L2 cache port between the instruction cache, the data cache and an internal next-line instruction prefetcher. It replaces the two-way I/D arbiter between the L1 caches and `l2_cache`. It keeps one pending prefetch and issues it only when both L1 caches are idle. Prefetch reads fill L2 only; their data is discarded.

---
 rtl/prefetch_arbiter_pkg.sv | 28 ++
 rtl/prefetch_arbiter.sv | 142 ++++++++++++++
 tb/tb_prefetch_arbiter.sv | 545 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prefetch_arbiter_pkg.sv
// Shared types and helpers for the three-way L2 port arbiter.
package arb_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LINE_W     = 256;
    localparam int unsigned LINE_BYTES = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_D  = 2'd1,
        SERVE_I  = 2'd2,
        SERVE_PF = 2'd3
    } arb_state_t;

    // One request as presented on the L2 port.
    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } l2_req_t;

    // Address of the line following the one containing addr.
    function automatic logic [ADDR_W-1:0] next_line(input logic [ADDR_W-1:0] addr);
        return (addr & ~ADDR_W'(LINE_BYTES - 1)) + ADDR_W'(LINE_BYTES);
    endfunction

endpackage

// File: rtl/prefetch_arbiter.sv
// Shares the L2 port between icache, dcache and a next-line instruction prefetcher.
module prefetch_arbiter
    import arb_pkg::*;
#(
    parameter bit          PF_ENABLE   = 1'b1,
    parameter int unsigned OFFSET_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_pmem_read,
    input  logic [ADDR_W-1:0]   i_pmem_address,
    output logic                i_pmem_resp,
    output logic [LINE_W-1:0]   i_pmem_rdata,
    input  logic                d_pmem_read,
    input  logic                d_pmem_write,
    input  logic [ADDR_W-1:0]   d_pmem_address,
    input  logic [LINE_W-1:0]   d_pmem_wdata,
    output logic                d_pmem_resp,
    output logic [LINE_W-1:0]   d_pmem_rdata,
    output logic                ab_pmem_read,
    output logic                ab_pmem_write,
    output logic [ADDR_W-1:0]   ab_pmem_address,
    output logic [LINE_W-1:0]   ab_pmem_wdata,
    input  logic                ab_pmem_resp,
    input  logic [LINE_W-1:0]   ab_pmem_rdata,
    output logic [ADDR_W-1:0]   prefetch_addr,
    input  logic                prefetch_present
);

    localparam int unsigned TAG_W = ADDR_W - OFFSET_BITS;

    arb_state_t        state, state_n;
    logic              last_d, last_d_n;
    logic              pf_valid, pf_valid_n;
    logic [ADDR_W-1:0] pf_addr, pf_addr_n;
    l2_req_t           req;

    logic              d_req;
    logic              i_req;
    logic [TAG_W-1:0]  i_line;
    logic [TAG_W-1:0]  pf_line;

    assign d_req   = d_pmem_read | d_pmem_write;
    assign i_req   = i_pmem_read;
    assign i_line  = i_pmem_address[ADDR_W-1:OFFSET_BITS];
    assign pf_line = pf_addr[ADDR_W-1:OFFSET_BITS];

    // Control registers; reset abandons any in-flight L2 access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            pf_valid <= 1'b0;
            pf_addr  <= '0;
        end else begin
            state    <= state_n;
            last_d   <= last_d_n;
            pf_valid <= pf_valid_n;
            pf_addr  <= pf_addr_n;
        end
    end

    // Grant decision, prefetch bookkeeping and owner-steered L2 port.
    always_comb begin
        state_n     = state;
        last_d_n    = last_d;
        pf_valid_n  = pf_valid;
        pf_addr_n   = pf_addr;
        req         = '0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;

        case (state)
            IDLE: begin
                // D wins alone or when I was served last; I otherwise.
                if (d_req && (!i_req || !last_d)) begin
                    state_n  = SERVE_D;
                    last_d_n = 1'b1;
                end else if (i_req) begin
                    state_n  = SERVE_I;
                    last_d_n = 1'b0;
                    // The icache fetches the pending line itself.
                    if (i_line == pf_line) begin
                        pf_valid_n = 1'b0;
                    end
                end else if (pf_valid) begin
                    if (prefetch_present) begin
                        pf_valid_n = 1'b0;
                    end else begin
                        state_n = SERVE_PF;
                    end
                end
            end

            SERVE_D: begin
                req.read    = d_pmem_read;
                req.write   = d_pmem_write;
                req.addr    = d_pmem_address;
                req.wdata   = d_pmem_wdata;
                d_pmem_resp = ab_pmem_resp;
                if (ab_pmem_resp) begin
                    state_n = IDLE;
                end
            end

            SERVE_I: begin
                req.read    = i_pmem_read;
                req.addr    = i_pmem_address;
                i_pmem_resp = ab_pmem_resp;
                if (ab_pmem_resp) begin
                    state_n = IDLE;
                    // Queue the next line, except past the top of memory.
                    if (PF_ENABLE && i_pmem_read && !(&i_line)) begin
                        pf_addr_n  = next_line(i_pmem_address);
                        pf_valid_n = 1'b1;
                    end
                end
            end

            SERVE_PF: begin
                req.read = 1'b1;
                req.addr = pf_addr;
                if (ab_pmem_resp) begin
                    state_n    = IDLE;
                    pf_valid_n = 1'b0;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign ab_pmem_read    = req.read;
    assign ab_pmem_write   = req.write;
    assign ab_pmem_address = req.addr;
    assign ab_pmem_wdata   = req.wdata;

    assign i_pmem_rdata  = ab_pmem_rdata;
    assign d_pmem_rdata  = ab_pmem_rdata;
    assign prefetch_addr = pf_addr;

endmodule

// File: tb/tb_prefetch_arbiter.sv
// Directed and randomized bench for prefetch_arbiter.
module tb_prefetch_arbiter;
    import arb_pkg::*;

    localparam bit PF_ON = 1'b1;
    localparam int O_NONE = 0;
    localparam int O_D    = 1;
    localparam int O_I    = 2;
    localparam int O_PF   = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic         i_pmem_resp;
    logic [255:0] i_pmem_rdata;
    logic         d_pmem_read, d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic         d_pmem_resp;
    logic [255:0] d_pmem_rdata;
    logic         ab_pmem_read, ab_pmem_write;
    logic [31:0]  ab_pmem_address;
    logic [255:0] ab_pmem_wdata;
    logic         ab_pmem_resp;
    logic [255:0] ab_pmem_rdata;
    logic [31:0]  prefetch_addr;
    logic         prefetch_present;

    logic         n_i_resp, n_d_resp, n_ab_read, n_ab_write;
    logic [255:0] n_i_rdata, n_d_rdata, n_ab_wdata;
    logic [31:0]  n_ab_addr, n_pf_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prefetch_arbiter #(.PF_ENABLE(PF_ON), .OFFSET_BITS(5)) dut (
        .clk(clk), .reset(reset),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
        .ab_pmem_read(ab_pmem_read), .ab_pmem_write(ab_pmem_write),
        .ab_pmem_address(ab_pmem_address), .ab_pmem_wdata(ab_pmem_wdata),
        .ab_pmem_resp(ab_pmem_resp), .ab_pmem_rdata(ab_pmem_rdata),
        .prefetch_addr(prefetch_addr), .prefetch_present(prefetch_present)
    );

    prefetch_arbiter #(.PF_ENABLE(1'b0), .OFFSET_BITS(5)) dut_nopf (
        .clk(clk), .reset(reset),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_resp(n_i_resp), .i_pmem_rdata(n_i_rdata),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_resp(n_d_resp), .d_pmem_rdata(n_d_rdata),
        .ab_pmem_read(n_ab_read), .ab_pmem_write(n_ab_write),
        .ab_pmem_address(n_ab_addr), .ab_pmem_wdata(n_ab_wdata),
        .ab_pmem_resp(ab_pmem_resp), .ab_pmem_rdata(ab_pmem_rdata),
        .prefetch_addr(n_pf_addr), .prefetch_present(prefetch_present)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_pmem_read      = 1'b0;
        i_pmem_address   = '0;
        d_pmem_read      = 1'b0;
        d_pmem_write     = 1'b0;
        d_pmem_address   = '0;
        d_pmem_wdata     = '0;
        ab_pmem_resp     = 1'b0;
        prefetch_present = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Lone icache read from IDLE, answered after lat serve cycles; ends in the following IDLE cycle.
    task automatic run_i(input logic [31:0] a, input int lat);
        i_pmem_read    = 1'b1;
        i_pmem_address = a;
        step();
        repeat (lat) step();
        ab_pmem_resp = 1'b1;
        step();
        ab_pmem_resp = 1'b0;
        i_pmem_read  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        ab_pmem_rdata = {8{$urandom}};
        #1;
        checks++;
        if ({ab_pmem_read, ab_pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {ab_pmem_read, ab_pmem_write, i_pmem_resp, d_pmem_resp});
        end
        checks++;
        if (ab_pmem_address !== 32'h0 || ab_pmem_wdata !== 256'h0 || prefetch_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h pf=%h expected 0", ab_pmem_address, prefetch_addr);
        end
        checks++;
        if (i_pmem_rdata !== ab_pmem_rdata || d_pmem_rdata !== ab_pmem_rdata) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected %h", i_pmem_rdata, ab_pmem_rdata);
        end
        ab_pmem_resp = 1'b1;
        #1;
        checks++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin
            errors++;
            $display("FAIL idle_stray_resp: got %b expected 00", {i_pmem_resp, d_pmem_resp});
        end
        ab_pmem_resp = 1'b0;
    endtask

    task automatic test_single_miss();
        do_reset();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_1000;
        #1;
        checks++;
        if (ab_pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL miss_grant_latency: got %b expected 0", ab_pmem_read);
        end
        step();
        checks++;
        if (ab_pmem_read !== 1'b1 || ab_pmem_address !== 32'h0000_1000) begin
            errors++;
            $display("FAIL miss_issue: got rd=%b addr=%h expected rd=1 addr=00001000", ab_pmem_read, ab_pmem_address);
        end
        repeat (3) step();
        ab_pmem_resp = 1'b1;
        #1;
        checks++;
        if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0) begin
            errors++;
            $display("FAIL miss_resp: got i=%b d=%b expected i=1 d=0", i_pmem_resp, d_pmem_resp);
        end
        step();
        ab_pmem_resp = 1'b0;
        i_pmem_read  = 1'b0;
        #1;
        checks++;
        if (ab_pmem_read !== 1'b0 || prefetch_addr !== 32'h0000_1020 || dut.pf_valid !== 1'b1) begin
            errors++;
            $display("FAIL miss_pf_capture: got rd=%b pf=%h v=%b expected rd=0 pf=00001020 v=1", ab_pmem_read, prefetch_addr, dut.pf_valid);
        end
        step();
        checks++;
        if (ab_pmem_read !== 1'b1 || ab_pmem_write !== 1'b0 || ab_pmem_address !== 32'h0000_1020) begin
            errors++;
            $display("FAIL pf_issue: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=00001020", ab_pmem_read, ab_pmem_write, ab_pmem_address);
        end
        ab_pmem_resp = 1'b1;
        #1;
        checks++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin
            errors++;
            $display("FAIL pf_resp_hidden: got %b expected 00", {i_pmem_resp, d_pmem_resp});
        end
        step();
        ab_pmem_resp = 1'b0;
        step();
        checks++;
        if (ab_pmem_read !== 1'b0 || dut.pf_valid !== 1'b0) begin
            errors++;
            $display("FAIL pf_done: got rd=%b v=%b expected rd=0 v=0", ab_pmem_read, dut.pf_valid);
        end
    endtask

    task automatic test_alternation();
        do_reset();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_2000;
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h0000_8000;
        d_pmem_wdata   = {8{32'hC0DE_0001}};
        step();
        checks++;
        if (ab_pmem_write !== 1'b1 || ab_pmem_read !== 1'b0 || ab_pmem_address !== 32'h0000_8000 || ab_pmem_wdata !== {8{32'hC0DE_0001}}) begin
            errors++;
            $display("FAIL pair1_d_first: got wr=%b rd=%b addr=%h expected wr=1 rd=0 addr=00008000", ab_pmem_write, ab_pmem_read, ab_pmem_address);
        end
        ab_pmem_resp = 1'b1;
        #1;
        checks++;
        if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin
            errors++;
            $display("FAIL pair1_d_resp: got d=%b i=%b expected d=1 i=0", d_pmem_resp, i_pmem_resp);
        end
        step();
        d_pmem_write = 1'b0;
        ab_pmem_resp = 1'b0;
        step();
        checks++;
        if (ab_pmem_read !== 1'b1 || ab_pmem_address !== 32'h0000_2000) begin
            errors++;
            $display("FAIL pair1_i_second: got rd=%b addr=%h expected rd=1 addr=00002000", ab_pmem_read, ab_pmem_address);
        end
        ab_pmem_resp = 1'b1;
        step();
        ab_pmem_resp   = 1'b0;
        i_pmem_address = 32'h0000_3000;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_9000;
        step();
        checks++;
        if (ab_pmem_read !== 1'b1 || ab_pmem_address !== 32'h0000_9000) begin
            errors++;
            $display("FAIL pair2_d_first: got rd=%b addr=%h expected rd=1 addr=00009000", ab_pmem_read, ab_pmem_address);
        end
        ab_pmem_resp = 1'b1;
        step();
        ab_pmem_resp = 1'b0;
        d_pmem_read  = 1'b0;
        step();
        checks++;
        if (ab_pmem_read !== 1'b1 || ab_pmem_address !== 32'h0000_3000) begin
            errors++;
            $display("FAIL pair2_i_second: got rd=%b addr=%h expected rd=1 addr=00003000", ab_pmem_read, ab_pmem_address);
        end
        ab_pmem_resp = 1'b1;
        step();
        ab_pmem_resp = 1'b0;
        i_pmem_read  = 1'b0;
        #1;
    endtask

    // Relies on the prefetch of 0x3020 left pending by test_alternation.
    task automatic test_pf_preempt();
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_4000;
        step();
        checks++;
        if (ab_pmem_address !== 32'h0000_4000 || ab_pmem_read !== 1'b1) begin
            errors++;
            $display("FAIL preempt_d_wins: got rd=%b addr=%h expected rd=1 addr=00004000", ab_pmem_read, ab_pmem_address);
        end
        ab_pmem_resp = 1'b1;
        step();
        ab_pmem_resp = 1'b0;
        d_pmem_read  = 1'b0;
        step();
        checks++;
        if (ab_pmem_read !== 1'b1 || ab_pmem_address !== 32'h0000_3020) begin
            errors++;
            $display("FAIL preempt_pf_after_d: got rd=%b addr=%h expected rd=1 addr=00003020", ab_pmem_read, ab_pmem_address);
        end
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_A000;
        step();
        ab_pmem_resp = 1'b1;
        #1;
        checks++;
        if (ab_pmem_address !== 32'h0000_3020 || d_pmem_resp !== 1'b0) begin
            errors++;
            $display("FAIL pf_not_preempted: got addr=%h dresp=%b expected addr=00003020 dresp=0", ab_pmem_address, d_pmem_resp);
        end
        step();
        ab_pmem_resp = 1'b0;
        step();
        checks++;
        if (ab_pmem_read !== 1'b1 || ab_pmem_address !== 32'h0000_A000) begin
            errors++;
            $display("FAIL d_after_pf: got rd=%b addr=%h expected rd=1 addr=0000a000", ab_pmem_read, ab_pmem_address);
        end
        ab_pmem_resp = 1'b1;
        step();
        clear_inputs();
        #1;
    endtask

    task automatic test_pf_suppress();
        do_reset();
        run_i(32'h0000_5000, 1);
        prefetch_present = 1'b1;
        #1;
        checks++;
        if (ab_pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL present_no_access: got rd=%b expected 0", ab_pmem_read);
        end
        step();
        prefetch_present = 1'b0;
        step();
        checks++;
        if (ab_pmem_read !== 1'b0 || dut.pf_valid !== 1'b0) begin
            errors++;
            $display("FAIL present_drop: got rd=%b v=%b expected rd=0 v=0", ab_pmem_read, dut.pf_valid);
        end
        run_i(32'h0000_6000, 0);
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_6020;
        step();
        checks++;
        if (dut.pf_valid !== 1'b0 || ab_pmem_address !== 32'h0000_6020) begin
            errors++;
            $display("FAIL same_line_drop: got v=%b addr=%h expected v=0 addr=00006020", dut.pf_valid, ab_pmem_address);
        end
        ab_pmem_resp = 1'b1;
        step();
        ab_pmem_resp = 1'b0;
        i_pmem_read  = 1'b0;
        #1;
        run_i(32'hFFFF_FFE0, 0);
        checks++;
        if (prefetch_addr !== 32'h0000_6040 || dut.pf_valid !== 1'b1) begin
            errors++;
            $display("FAIL top_line_suppress: got pf=%h v=%b expected pf=00006040 v=1", prefetch_addr, dut.pf_valid);
        end
        step();
        checks++;
        if (ab_pmem_read !== 1'b1 || ab_pmem_address !== 32'h0000_6040) begin
            errors++;
            $display("FAIL old_pf_kept: got rd=%b addr=%h expected rd=1 addr=00006040", ab_pmem_read, ab_pmem_address);
        end
        ab_pmem_resp = 1'b1;
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_i(32'h0000_7000, 0);
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h0000_7700;
        d_pmem_wdata   = {8{32'hDEAD_BEEF}};
        step();
        checks++;
        if (ab_pmem_write !== 1'b1 || ab_pmem_address !== 32'h0000_7700) begin
            errors++;
            $display("FAIL wb_issue: got wr=%b addr=%h expected wr=1 addr=00007700", ab_pmem_write, ab_pmem_address);
        end
        reset = 1'b1;
        step();
        reset        = 1'b0;
        d_pmem_write = 1'b0;
        #1;
        checks++;
        if ({ab_pmem_read, ab_pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0 || ab_pmem_address !== 32'h0 || ab_pmem_wdata !== 256'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rd=%b wr=%b addr=%h expected all 0", ab_pmem_read, ab_pmem_write, ab_pmem_address);
        end
        checks++;
        if (prefetch_addr !== 32'h0 || dut.pf_valid !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL mid_reset_state: got pf=%h v=%b st=%0d expected 0 0 0", prefetch_addr, dut.pf_valid, dut.state);
        end
        ab_pmem_resp = 1'b1;
        #1;
        checks++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin
            errors++;
            $display("FAIL stray_resp: got %b expected 00", {i_pmem_resp, d_pmem_resp});
        end
        step();
        ab_pmem_resp = 1'b0;
        step();
        checks++;
        if (ab_pmem_read !== 1'b0 || ab_pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL after_stray: got rd=%b wr=%b expected 0 0", ab_pmem_read, ab_pmem_write);
        end
    endtask

    task automatic test_pf_disable();
        do_reset();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_1000;
        step();
        checks++;
        if (n_ab_read !== 1'b1 || n_ab_addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL nopf_issue: got rd=%b addr=%h expected rd=1 addr=00001000", n_ab_read, n_ab_addr);
        end
        repeat (3) step();
        ab_pmem_resp = 1'b1;
        #1;
        checks++;
        if (n_i_resp !== 1'b1) begin
            errors++;
            $display("FAIL nopf_resp: got %b expected 1", n_i_resp);
        end
        step();
        clear_inputs();
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (n_ab_read !== 1'b0 || n_pf_addr !== 32'h0) begin
                errors++;
                $display("FAIL nopf_idle: cycle %0d got rd=%b pf=%h expected rd=0 pf=0", k, n_ab_read, n_pf_addr);
            end
            step();
        end
    endtask

    task automatic test_random();
        int          m_owner;
        bit          m_last_d;
        bit          m_pfv;
        logic [31:0] m_pf;
        int          lat;
        bit          i_drop, d_drop;
        int          nxt;
        logic        e_read, e_write, e_iresp, e_dresp;
        logic [31:0] e_addr;

        do_reset();
        m_owner = O_NONE; m_last_d = 1'b0; m_pfv = 1'b0; m_pf = '0;
        lat = 0; i_drop = 1'b0; d_drop = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (i_drop) begin
                i_pmem_read = 1'b0;
                i_drop      = 1'b0;
            end else if (!i_pmem_read && $urandom_range(0, 2) == 0) begin
                i_pmem_read = 1'b1;
                case ($urandom_range(0, 5))
                    0:       i_pmem_address = m_pf | 32'($urandom_range(0, 31));
                    1:       i_pmem_address = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
                    default: i_pmem_address = 32'h1000 + (32'($urandom_range(0, 7)) << 5) + 32'($urandom_range(0, 31));
                endcase
            end
            if (d_drop) begin
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
                d_drop       = 1'b0;
            end else if (!d_pmem_read && !d_pmem_write && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) d_pmem_write = 1'b1;
                else                           d_pmem_read  = 1'b1;
                d_pmem_address = 32'h8000 + (32'($urandom_range(0, 63)) << 5);
                d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
            if (m_owner != O_NONE) begin
                ab_pmem_resp = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                ab_pmem_resp = ($urandom_range(0, 5) == 0);
            end
            prefetch_present = ($urandom_range(0, 2) == 0);
            ab_pmem_rdata    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            #1;

            e_read = 1'b0; e_write = 1'b0; e_addr = '0;
            if (m_owner == O_D) begin
                e_read = d_pmem_read; e_write = d_pmem_write; e_addr = d_pmem_address;
            end else if (m_owner == O_I) begin
                e_read = i_pmem_read; e_addr = i_pmem_address;
            end else if (m_owner == O_PF) begin
                e_read = 1'b1; e_addr = m_pf;
            end
            e_iresp = (m_owner == O_I) && ab_pmem_resp;
            e_dresp = (m_owner == O_D) && ab_pmem_resp;

            checks++;
            if ({ab_pmem_read, ab_pmem_write, i_pmem_resp, d_pmem_resp} !== {e_read, e_write, e_iresp, e_dresp}) begin
                errors++;
                $display("FAIL rnd_ctrl: cycle %0d got rd/wr/ir/dr=%b expected %b", cyc,
                         {ab_pmem_read, ab_pmem_write, i_pmem_resp, d_pmem_resp}, {e_read, e_write, e_iresp, e_dresp});
            end
            if (m_owner != O_NONE) begin
                checks++;
                if (ab_pmem_address !== e_addr) begin
                    errors++;
                    $display("FAIL rnd_addr: cycle %0d got %h expected %h", cyc, ab_pmem_address, e_addr);
                end
            end
            if (m_owner == O_D) begin
                checks++;
                if (ab_pmem_wdata !== d_pmem_wdata) begin
                    errors++;
                    $display("FAIL rnd_wdata: cycle %0d got %h expected %h", cyc, ab_pmem_wdata, d_pmem_wdata);
                end
            end
            checks++;
            if (prefetch_addr !== m_pf || i_pmem_rdata !== ab_pmem_rdata || d_pmem_rdata !== ab_pmem_rdata) begin
                errors++;
                $display("FAIL rnd_pf_rdata: cycle %0d got pf=%h expected pf=%h", cyc, prefetch_addr, m_pf);
            end

            if (m_owner != O_NONE) begin
                if (ab_pmem_resp) begin
                    if (m_owner == O_I) begin
                        i_drop = 1'b1;
                        if (PF_ON && (i_pmem_address >> 5) != 32'h07FF_FFFF) begin
                            m_pf  = (i_pmem_address & ~32'd31) + 32'd32;
                            m_pfv = 1'b1;
                        end
                    end
                    if (m_owner == O_D)  d_drop = 1'b1;
                    if (m_owner == O_PF) m_pfv  = 1'b0;
                    m_owner = O_NONE;
                end
            end else begin
                if ((d_pmem_read || d_pmem_write) && i_pmem_read) nxt = m_last_d ? O_I : O_D;
                else if (d_pmem_read || d_pmem_write)             nxt = O_D;
                else if (i_pmem_read)                             nxt = O_I;
                else if (m_pfv && !prefetch_present)              nxt = O_PF;
                else                                              nxt = O_NONE;
                if (nxt == O_NONE && m_pfv && prefetch_present) m_pfv = 1'b0;
                if (nxt == O_D) m_last_d = 1'b1;
                if (nxt == O_I) begin
                    m_last_d = 1'b0;
                    if ((i_pmem_address >> 5) == (m_pf >> 5)) m_pfv = 1'b0;
                end
                m_owner = nxt;
                lat     = $urandom_range(0, 3);
            end
        end
        clear_inputs();
    endtask

    initial begin
        reset         = 1'b1;
        ab_pmem_rdata = '0;
        clear_inputs();
        test_reset();
        test_single_miss();
        test_alternation();
        test_pf_preempt();
        test_pf_suppress();
        test_reset_mid();
        test_pf_disable();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
